hex_display_driver: RTL and testbench

- Downstream of the processor's hex output-select stage.
- Takes its four 4-bit digit nibbles (Hex7..Hex4) and drives four active-low 7-segment displays.
- Adds a debounced freeze/snapshot key so the operator can hold the shown value while the processor keeps running.
- Adds a "recently changed" indicator for an LED.

---
 rtl/hex_display_driver.sv | 118 +++++++++++
 tb/tb_hex_display_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_driver.sv
// Four-digit active-low 7-segment driver with a debounced freeze key and a
// "recently changed" indicator for an LED.
module hex_display_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CHANGE_CYCLES   = 12500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Hex7In,
  input  logic [3:0] Hex6In,
  input  logic [3:0] Hex5In,
  input  logic [3:0] Hex4In,
  input  logic       FreezeKey,
  input  logic       Blank,
  output logic [6:0] HEX7,
  output logic [6:0] HEX6,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic       Frozen,
  output logic       Changed
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CW = $clog2(CHANGE_CYCLES + 1);

  logic          key_s1;
  logic          key_s2;
  logic          key_deb;
  logic [DW-1:0] deb_cnt;
  logic          deb_done_c;
  logic          press_c;
  logic [15:0]   disp;
  logic [15:0]   live_c;
  logic [CW-1:0] chg_cnt;

  assign live_c     = {Hex7In, Hex6In, Hex5In, Hex4In};
  assign deb_done_c = (key_s2 != key_deb) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  // Press is the cycle the debounced level falls; release is ignored.
  assign press_c    = deb_done_c && key_deb;

  // Key synchronizer and debouncer; idle level is 1 (key released).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      key_deb <= 1'b1;
      deb_cnt <= '0;
    end else begin
      key_s1 <= FreezeKey;
      key_s2 <= key_s1;
      if (key_s2 == key_deb) begin
        deb_cnt <= '0;
      end else if (deb_done_c) begin
        key_deb <= key_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Freeze toggle, display capture and change-hold counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Frozen  <= 1'b0;
      disp    <= '0;
      chg_cnt <= '0;
    end else begin
      if (press_c) begin
        Frozen <= ~Frozen;
      end
      if (Frozen) begin
        chg_cnt <= '0;
      end else begin
        disp <= live_c;
        if (live_c != disp) begin
          chg_cnt <= CW'(CHANGE_CYCLES);
        end else if (chg_cnt != '0) begin
          chg_cnt <= chg_cnt - CW'(1);
        end
      end
    end
  end

  assign Changed = (chg_cnt != '0);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Blank overrides the decoders immediately without touching stored state.
  always_comb begin
    HEX7 = Blank ? 7'h7F : seg7(disp[15:12]);
    HEX6 = Blank ? 7'h7F : seg7(disp[11:8]);
    HEX5 = Blank ? 7'h7F : seg7(disp[7:4]);
    HEX4 = Blank ? 7'h7F : seg7(disp[3:0]);
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: window-based key model, per-cycle compare,
// and directed scenarios with literal expectations.
module tb_hex_display_driver;

  localparam int unsigned D = 4;
  localparam int unsigned C = 8;

  logic       Clk;
  logic       Reset;
  logic [3:0] Hex7In, Hex6In, Hex5In, Hex4In;
  logic       FreezeKey;
  logic       Blank;
  logic [6:0] HEX7, HEX6, HEX5, HEX4;
  logic       Frozen;
  logic       Changed;

  int checks   = 0;
  int failures = 0;

  hex_display_driver #(.DEBOUNCE_CYCLES(D), .CHANGE_CYCLES(C)) dut (
    .Clk(Clk), .Reset(Reset),
    .Hex7In(Hex7In), .Hex6In(Hex6In), .Hex5In(Hex5In), .Hex4In(Hex4In),
    .FreezeKey(FreezeKey), .Blank(Blank),
    .HEX7(HEX7), .HEX6(HEX6), .HEX5(HEX5), .HEX4(HEX4),
    .Frozen(Frozen), .Changed(Changed)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the debounced level flips once the raw key has been sampled at the
  // opposite level for D consecutive edges, seen two edges late.
  logic [D+1:0] hist, nh;
  logic [D-1:0] win;
  logic         deb_m, frz_m, press_m;
  logic [15:0]  disp_m, live_m;
  int           cnt_m;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hist   <= '1;
      deb_m  <= 1'b1;
      frz_m  <= 1'b0;
      disp_m <= '0;
      cnt_m  <= 0;
    end else begin
      nh      = {hist[D:0], FreezeKey};
      win     = nh[D+1:2];
      press_m = deb_m && (win == '0);
      hist   <= nh;
      if (press_m) deb_m <= 1'b0;
      else if (!deb_m && (&win)) deb_m <= 1'b1;
      live_m = {Hex7In, Hex6In, Hex5In, Hex4In};
      if (frz_m) begin
        cnt_m <= 0;
      end else begin
        disp_m <= live_m;
        if (live_m != disp_m) cnt_m <= C;
        else if (cnt_m != 0) cnt_m <= cnt_m - 1;
      end
      if (press_m) frz_m <= !frz_m;
    end
  end

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    return Blank ? 7'h7F : seg_tab[d];
  endfunction

  // Per-cycle comparison against the model, mid-low-phase.
  always @(negedge Clk) begin
    #2;
    chk("hex7", 32'(HEX7), 32'(exp_seg(disp_m[15:12])));
    chk("hex6", 32'(HEX6), 32'(exp_seg(disp_m[11:8])));
    chk("hex5", 32'(HEX5), 32'(exp_seg(disp_m[7:4])));
    chk("hex4", 32'(HEX4), 32'(exp_seg(disp_m[3:0])));
    chk("frozen", 32'(Frozen), 32'(frz_m));
    chk("changed", 32'(Changed), 32'(cnt_m != 0));
  end

  task automatic set_all(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    Hex7In = a; Hex6In = b; Hex5In = c; Hex4In = d;
  endtask

  task automatic hold_key(input logic v, input int n);
    FreezeKey = v;
    repeat (n) @(negedge Clk);
  endtask

  // Bounded wait for Frozen to reach v; a timeout counts as a failure.
  task automatic wait_frozen(input logic v, input string name);
    int n;
    n = 0;
    while (Frozen !== v && n < 30) begin
      @(negedge Clk); #3;
      n++;
    end
    chk(name, 32'(Frozen), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b0; FreezeKey = 1'b1; Blank = 1'b0;
    set_all(4'h0, 4'h0, 4'h0, 4'h0);
    #1 Reset = 1'b1;

    // 1: reset state, then first capture and change window
    repeat (2) @(negedge Clk);
    #3;
    chk("rst_hex7", 32'(HEX7), 32'(7'b1000000));
    chk("rst_hex4", 32'(HEX4), 32'(7'b1000000));
    chk("rst_frozen", 32'(Frozen), 32'(1'b0));
    chk("rst_changed", 32'(Changed), 32'(1'b0));
    @(negedge Clk) Reset = 1'b0;
    repeat (2) @(negedge Clk);
    set_all(4'h1, 4'h2, 4'hA, 4'hF);
    @(negedge Clk); #3;
    chk("t1_hex7", 32'(HEX7), 32'(7'b1111001));
    chk("t1_hex6", 32'(HEX6), 32'(7'b0100100));
    chk("t1_hex5", 32'(HEX5), 32'(7'b0001000));
    chk("t1_hex4", 32'(HEX4), 32'(7'b0001110));
    n = Changed ? 1 : 0;
    repeat (15) begin
      @(negedge Clk); #3;
      if (Changed) n++;
    end
    chk("t1_changed_len", 32'(n), 32'(8));

    // 2: bouncing press, latency from the last bounce, no toggle on release
    @(negedge Clk);
    hold_key(1'b0, 2); hold_key(1'b1, 2);
    hold_key(1'b0, 2); hold_key(1'b1, 2);
    FreezeKey = 1'b0;
    n = 0;
    while (Frozen !== 1'b1 && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("t2_press_latency", 32'(n), 32'(D + 2));
    repeat (10) @(negedge Clk);
    hold_key(1'b1, 12);
    #3;
    chk("t2_release_no_toggle", 32'(Frozen), 32'(1'b1));

    // 3: frozen hold through an input sweep, then unfreeze onto a new value
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      set_all(4'(i), 4'(i), 4'(i), 4'(i));
    end
    @(negedge Clk); #3;
    chk("t3_hold_hex7", 32'(HEX7), 32'(7'b1111001));
    chk("t3_hold_hex4", 32'(HEX4), 32'(7'b0001110));
    chk("t3_hold_changed", 32'(Changed), 32'(1'b0));
    set_all(4'h3, 4'h3, 4'h3, 4'h3);
    FreezeKey = 1'b0;
    wait_frozen(1'b0, "t3_unfreeze");
    @(negedge Clk); #3;
    chk("t3_track_hex7", 32'(HEX7), 32'(7'b0110000));
    chk("t3_track_changed", 32'(Changed), 32'(1'b1));
    @(negedge Clk);
    hold_key(1'b1, 12);

    // 4: input change on the press-pulse cycle is captured, then held
    FreezeKey = 1'b0;
    repeat (5) @(negedge Clk);
    set_all(4'h8, 4'h8, 4'h8, 4'h8);
    @(negedge Clk);
    set_all(4'h5, 4'h6, 4'h7, 4'h9);
    #3;
    chk("t4_hex7", 32'(HEX7), 32'(7'b0000000));
    chk("t4_hex4", 32'(HEX4), 32'(7'b0000000));
    chk("t4_frozen", 32'(Frozen), 32'(1'b1));
    repeat (3) @(negedge Clk);
    #3;
    chk("t4_hold_hex5", 32'(HEX5), 32'(7'b0000000));
    @(negedge Clk);
    hold_key(1'b1, 12);
    FreezeKey = 1'b0;
    wait_frozen(1'b0, "t4_unfreeze");
    @(negedge Clk);
    hold_key(1'b1, 12);

    // 5: Blank mid-sweep is immediate and lossless
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      set_all(4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3));
      if (i == 4) begin
        Blank = 1'b1;
        #3;
        chk("t5_blank_hex7", 32'(HEX7), 32'(7'h7F));
        chk("t5_blank_hex4", 32'(HEX4), 32'(7'h7F));
      end
      if (i == 6) begin
        Blank = 1'b0;
        #3;
        chk("t5_unblank_hex7", 32'(HEX7), 32'(7'b0010010));
        chk("t5_unblank_hex4", 32'(HEX4), 32'(7'b0000000));
      end
    end

    // 6: reset during a change count and a pending key debounce
    @(negedge Clk);
    set_all(4'hC, 4'hD, 4'hE, 4'hF);
    FreezeKey = 1'b0;
    repeat (3) @(negedge Clk);
    #3;
    chk("t6_changed_before", 32'(Changed), 32'(1'b1));
    Reset = 1'b1;
    #1;
    chk("t6_rst_changed", 32'(Changed), 32'(1'b0));
    chk("t6_rst_frozen", 32'(Frozen), 32'(1'b0));
    chk("t6_rst_hex7", 32'(HEX7), 32'(7'b1000000));
    FreezeKey = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (15) @(negedge Clk);
    #3;
    chk("t6_no_press", 32'(Frozen), 32'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
